// File: rtl/cart_bus_arb_if.sv
// CPU data bus, IRQ and ROM request bundle for cart_bus_arb.
// slave = arbiter side, master = CPU/channel side.
interface cart_bus_arb_if #(
   parameter int unsigned NCH = 4,
   parameter int unsigned AW  = 24
);
   logic              SYSCLKF_CE;
   logic              CPURD_N;
   logic [NCH-1:0]    CH_SEL;
   logic [NCH*8-1:0]  CH_DO;
   logic [7:0]        DI;
   logic              COLLISION;
   logic [NCH-1:0]    CH_IRQ;
   logic [NCH-1:0]    IRQ_MASK;
   logic              IRQ_N;
   logic [NCH-1:0]    ROM_REQ;
   logic [NCH*AW-1:0] ROM_ADDR_IN;
   logic [NCH-1:0]    ROM_GNT;
   logic [AW-1:0]     ROM_ADDR;
   logic              ROM_CE_N;

   modport slave (
      input  SYSCLKF_CE, CPURD_N, CH_SEL, CH_DO, CH_IRQ, IRQ_MASK, ROM_REQ, ROM_ADDR_IN,
      output DI, COLLISION, IRQ_N, ROM_GNT, ROM_ADDR, ROM_CE_N
   );

   modport master (
      output SYSCLKF_CE, CPURD_N, CH_SEL, CH_DO, CH_IRQ, IRQ_MASK, ROM_REQ, ROM_ADDR_IN,
      input  DI, COLLISION, IRQ_N, ROM_GNT, ROM_ADDR, ROM_CE_N
   );
endinterface

// File: rtl/cart_bus_arb.sv
// Cartridge expansion bus arbiter: CPU read mux with open bus, IRQ merge, ROM arbiter.
// Optional collision counter output COLL_CNT enabled by `define CART_BUS_ARB_COLL_CNT_EN.
module cart_bus_arb #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned AW      = 24,
   parameter int unsigned PRIO_RR = 1
) (
   input  logic           MCLK,
   input  logic           RESET,
   cart_bus_arb_if.slave  bus
`ifdef CART_BUS_ARB_COLL_CNT_EN
   ,
   output logic [7:0]     COLL_CNT
`endif
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [NCH-1:0] SelOne = NCH'(1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e         state_q, state_d;
   logic [IW-1:0]  win_q, win_d;
   logic [IW-1:0]  last_q, last_d;
   logic [IW-1:0]  pick;
   logic [7:0]     ob_q;
   logic           coll_q;
   logic           irq_n_q;
   logic [7:0]     di;
   logic           sel_any;
   logic           sel_multi;
   logic           rd_strobe;

   assign rd_strobe = bus.SYSCLKF_CE & ~bus.CPURD_N;
   assign sel_any   = |bus.CH_SEL;
   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign sel_multi = |(bus.CH_SEL & (bus.CH_SEL - SelOne));

   always_comb begin
      di = ob_q;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (bus.CH_SEL[i]) di = bus.CH_DO[8*i +: 8];
      end
   end

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         ob_q    <= 8'hFF;
         coll_q  <= 1'b0;
         irq_n_q <= 1'b1;
      end else begin
         if (rd_strobe && sel_any) ob_q <= di;
         coll_q  <= rd_strobe & sel_multi;
         irq_n_q <= ~|(bus.CH_IRQ & bus.IRQ_MASK);
      end
   end

   assign bus.DI        = di;
   assign bus.COLLISION = coll_q;
   assign bus.IRQ_N     = irq_n_q;

   // Winner selection; the RR scan runs farthest-first so the nearest requester after
   // the previous winner overwrites the others.
   always_comb begin
      logic [IW-1:0] idx;
      pick = '0;
      idx  = '0;
      if (PRIO_RR != 0) begin
         for (int unsigned k = NCH; k >= 1; k--) begin
            idx = IW'((32'(last_q) + k) % NCH);
            if (bus.ROM_REQ[idx]) pick = idx;
         end
      end else begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.ROM_REQ[i]) pick = IW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (|bus.ROM_REQ) begin
               win_d   = pick;
               last_d  = pick;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (!bus.ROM_REQ[win_q]) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
         win_q   <= '0;
         last_q  <= IW'(NCH - 1);
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
      end
   end

   // Grant outputs decode straight from the state register so reset clears them at once.
   always_comb begin
      bus.ROM_GNT  = '0;
      bus.ROM_CE_N = 1'b1;
      bus.ROM_ADDR = '0;
      if (state_q == StGrant) begin
         bus.ROM_GNT[win_q] = 1'b1;
         bus.ROM_CE_N       = 1'b0;
         bus.ROM_ADDR       = bus.ROM_ADDR_IN[32'(win_q) * AW +: AW];
      end
   end

`ifdef CART_BUS_ARB_COLL_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= 8'd0;
      end else if (rd_strobe && sel_multi && (cnt_q != 8'hFF)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign COLL_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_cart_bus_arb.sv
// Scoreboard bench for cart_bus_arb: one round-robin and one fixed-priority instance
// share stimulus; a transaction-level model feeds expectations to a monitor queue.
module tb_cart_bus_arb;
   localparam int unsigned NCH = 4;
   localparam int unsigned AW  = 24;

   logic MCLK  = 1'b0;
   logic RESET = 1'b1;
   always #5 MCLK = ~MCLK;

   cart_bus_arb_if #(.NCH(NCH), .AW(AW)) bus_rr ();
   cart_bus_arb_if #(.NCH(NCH), .AW(AW)) bus_fx ();

`ifdef CART_BUS_ARB_COLL_CNT_EN
   logic [7:0] cnt_rr, cnt_fx;
   cart_bus_arb #(.NCH(NCH), .AW(AW), .PRIO_RR(1)) dut_rr (
      .MCLK(MCLK), .RESET(RESET), .bus(bus_rr), .COLL_CNT(cnt_rr));
   cart_bus_arb #(.NCH(NCH), .AW(AW), .PRIO_RR(0)) dut_fx (
      .MCLK(MCLK), .RESET(RESET), .bus(bus_fx), .COLL_CNT(cnt_fx));
`else
   cart_bus_arb #(.NCH(NCH), .AW(AW), .PRIO_RR(1)) dut_rr (
      .MCLK(MCLK), .RESET(RESET), .bus(bus_rr));
   cart_bus_arb #(.NCH(NCH), .AW(AW), .PRIO_RR(0)) dut_fx (
      .MCLK(MCLK), .RESET(RESET), .bus(bus_fx));
`endif

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus staging (s_*) and values currently on the pins (a_*).
   logic              s_rst, s_ce, s_rd_n;
   logic [NCH-1:0]    s_sel, s_irq, s_mask, s_req;
   logic [NCH*8-1:0]  s_do;
   logic [NCH*AW-1:0] s_addr;
   logic              a_rst, a_ce, a_rd_n;
   logic [NCH-1:0]    a_sel, a_irq, a_mask, a_req;
   logic [NCH*8-1:0]  a_do;
   logic [NCH*AW-1:0] a_addr;

   // Reference model state.
   logic [7:0] m_ob;
   logic       m_coll;
   logic       m_irq_n;
   int         m_cnt;
   int         own_rr, own_fx, prev_rr;

   typedef struct {
      logic [7:0]     di;
      logic           coll;
      logic           irq_n;
      logic [NCH-1:0] gnt_rr, gnt_fx;
      logic           ce_rr, ce_fx;
      logic [AW-1:0]  addr_rr, addr_fx;
      logic [7:0]     cnt;
   } exp_t;
   exp_t sb[$];

   bit   rec_order = 1'b0;
   int   order[$];

   function automatic logic [7:0] exp_di();
      for (int i = 0; i < int'(NCH); i++) if (a_sel[i]) return a_do[8*i +: 8];
      return m_ob;
   endfunction

   function automatic int pick_rr(input logic [NCH-1:0] req, input int prev);
      for (int k = 1; k <= int'(NCH); k++) begin
         int idx = (prev + k) % int'(NCH);
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic int pick_fx(input logic [NCH-1:0] req);
      for (int i = 0; i < int'(NCH); i++) if (req[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_ob = 8'hFF; m_coll = 1'b0; m_irq_n = 1'b1; m_cnt = 0;
      own_rr = -1; own_fx = -1; prev_rr = int'(NCH) - 1;
   endtask

   task automatic model_edge();
      bit rd;
      int n, p;
      if (a_rst) return;
      rd = a_ce && !a_rd_n;
      n  = $countones(a_sel);
      if (rd && n > 0) m_ob = exp_di();
      m_coll = rd && (n >= 2);
      if (m_coll && m_cnt < 255) m_cnt++;
      m_irq_n = ((a_irq & a_mask) == '0);
      if (own_rr < 0) begin
         p = pick_rr(a_req, prev_rr);
         if (p >= 0) begin own_rr = p; prev_rr = p; end
      end else if (!a_req[own_rr]) own_rr = -1;
      if (own_fx < 0) own_fx = pick_fx(a_req);
      else if (!a_req[own_fx]) own_fx = -1;
   endtask

   task automatic drive_bus();
      bus_rr.SYSCLKF_CE = a_ce;  bus_fx.SYSCLKF_CE = a_ce;
      bus_rr.CPURD_N = a_rd_n;   bus_fx.CPURD_N = a_rd_n;
      bus_rr.CH_SEL = a_sel;     bus_fx.CH_SEL = a_sel;
      bus_rr.CH_DO = a_do;       bus_fx.CH_DO = a_do;
      bus_rr.CH_IRQ = a_irq;     bus_fx.CH_IRQ = a_irq;
      bus_rr.IRQ_MASK = a_mask;  bus_fx.IRQ_MASK = a_mask;
      bus_rr.ROM_REQ = a_req;    bus_fx.ROM_REQ = a_req;
      bus_rr.ROM_ADDR_IN = a_addr; bus_fx.ROM_ADDR_IN = a_addr;
   endtask

   // One bus cycle: apply at negedge, queue the expectation, advance the model at posedge.
   task automatic cycle();
      exp_t e;
      @(negedge MCLK);
      a_rst = s_rst; a_ce = s_ce; a_rd_n = s_rd_n; a_sel = s_sel; a_do = s_do;
      a_irq = s_irq; a_mask = s_mask; a_req = s_req; a_addr = s_addr;
      drive_bus();
      RESET = a_rst;
      if (a_rst) model_reset();
      e.di      = exp_di();
      e.coll    = m_coll;
      e.irq_n   = m_irq_n;
      e.gnt_rr  = (own_rr >= 0) ? NCH'(1) << own_rr : '0;
      e.ce_rr   = (own_rr < 0);
      e.addr_rr = (own_rr >= 0) ? a_addr[own_rr*AW +: AW] : '0;
      e.gnt_fx  = (own_fx >= 0) ? NCH'(1) << own_fx : '0;
      e.ce_fx   = (own_fx < 0);
      e.addr_fx = (own_fx >= 0) ? a_addr[own_fx*AW +: AW] : '0;
      e.cnt     = 8'(m_cnt);
      sb.push_back(e);
      @(posedge MCLK);
      model_edge();
   endtask

   // Monitor: samples mid-low-phase, after inputs have settled.
   initial begin
      exp_t e;
      logic [NCH-1:0] prev_gnt = '0;
      forever begin
         @(negedge MCLK);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("di", 32'(bus_rr.DI), 32'(e.di));
            chk("di_fx", 32'(bus_fx.DI), 32'(e.di));
            chk("collision", 32'(bus_rr.COLLISION), 32'(e.coll));
            chk("irq_n", 32'(bus_rr.IRQ_N), 32'(e.irq_n));
            chk("gnt_rr", 32'(bus_rr.ROM_GNT), 32'(e.gnt_rr));
            chk("ce_n_rr", 32'(bus_rr.ROM_CE_N), 32'(e.ce_rr));
            chk("addr_rr", 32'(bus_rr.ROM_ADDR), 32'(e.addr_rr));
            chk("gnt_fx", 32'(bus_fx.ROM_GNT), 32'(e.gnt_fx));
            chk("ce_n_fx", 32'(bus_fx.ROM_CE_N), 32'(e.ce_fx));
            chk("addr_fx", 32'(bus_fx.ROM_ADDR), 32'(e.addr_fx));
`ifdef CART_BUS_ARB_COLL_CNT_EN
            chk("coll_cnt", 32'(cnt_rr), 32'(e.cnt));
            chk("coll_cnt_fx", 32'(cnt_fx), 32'(e.cnt));
`endif
            if (rec_order && prev_gnt == '0 && bus_rr.ROM_GNT != '0) begin
               for (int i = 0; i < int'(NCH); i++) if (bus_rr.ROM_GNT[i]) order.push_back(i);
            end
            prev_gnt = bus_rr.ROM_GNT;
         end
      end
   end

   task automatic idle_inputs();
      s_ce = 1'b0; s_rd_n = 1'b1; s_sel = '0; s_do = '0; s_irq = '0; s_mask = '0;
      s_req = '0; s_addr = '0;
   endtask

   initial begin
      int gcnt;
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      model_reset();
      idle_inputs();
      s_rst = 1'b1;
      cycle();
      cycle();
      s_rst = 1'b0;

      // Round-robin rotation with all channels requesting, 3 grant cycles each.
      rec_order = 1'b1;
      gcnt = 0;
      for (int c = 0; c < 20; c++) begin
         s_req = '1;
         for (int i = 0; i < int'(NCH); i++) s_addr[i*AW +: AW] = AW'(32'h100000 * (i + 1) + c);
         if (own_rr >= 0 && gcnt == 3) s_req[own_rr] = 1'b0;
         cycle();
         gcnt = (own_rr >= 0) ? gcnt + 1 : 0;
      end
      s_req = '0;
      cycle();
      cycle();
      rec_order = 1'b0;
      chk("rr_order_len", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));

      // Single claim then open bus.
      s_ce = 1'b1; s_rd_n = 1'b0; s_sel = 4'b0100; s_do = '0; s_do[8*2 +: 8] = 8'h5A;
      cycle();
      s_ce = 1'b0; s_sel = '0; s_do = 32'hDEADBEEF;
      cycle();
      // Two claimants: lowest wins, one-cycle collision pulse.
      s_ce = 1'b1; s_sel = 4'b0011; s_do = '0; s_do[7:0] = 8'h11; s_do[15:8] = 8'h22;
      cycle();
      s_ce = 1'b0; s_sel = '0;
      cycle();
      cycle();
      // Masked vs unmasked IRQ.
      s_irq = 4'b1000; s_mask = 4'b0111;
      cycle();
      cycle();
      s_mask = 4'b1000;
      cycle();
      cycle();

      // Randomized traffic with occasional reset pulses.
      for (int c = 0; c < 400; c++) begin
         s_rst  = ($urandom_range(0, 99) == 0);
         s_ce   = 1'($urandom_range(0, 1));
         s_rd_n = ($urandom_range(0, 3) == 0);
         s_sel  = ($urandom_range(0, 2) == 0) ? '0 : NCH'($urandom) & NCH'($urandom);
         for (int i = 0; i < int'(NCH); i++) s_do[8*i +: 8] = 8'($urandom);
         s_irq  = NCH'($urandom);
         s_mask = NCH'($urandom);
         if ($urandom_range(0, 3) == 0) s_req = NCH'($urandom);
         for (int i = 0; i < int'(NCH); i++) s_addr[i*AW +: AW] = AW'($urandom);
         cycle();
      end
      s_rst = 1'b0;
      idle_inputs();
      cycle();
      cycle();

      // Fixed priority grant, then asynchronous reset in the middle of it.
      s_req = 4'b0110; s_addr = '0; s_addr[1*AW +: AW] = 24'h123456;
      s_ce = 1'b1; s_rd_n = 1'b0; s_sel = 4'b0011; s_irq = 4'b0001; s_mask = 4'b0001;
      cycle();
      cycle();
      #3;
      chk("pre_rst_gnt_fx", 32'(bus_fx.ROM_GNT), 32'h2);
      chk("pre_rst_addr_fx", 32'(bus_fx.ROM_ADDR), 32'h123456);
      RESET = 1'b1;
      #1;
      chk("rst_gnt_fx", 32'(bus_fx.ROM_GNT), 32'h0);
      chk("rst_ce_n_fx", 32'(bus_fx.ROM_CE_N), 32'h1);
      chk("rst_addr_fx", 32'(bus_fx.ROM_ADDR), 32'h0);
      chk("rst_gnt_rr", 32'(bus_rr.ROM_GNT), 32'h0);
      chk("rst_ce_n_rr", 32'(bus_rr.ROM_CE_N), 32'h1);
      chk("rst_irq_n", 32'(bus_fx.IRQ_N), 32'h1);
      chk("rst_collision", 32'(bus_fx.COLLISION), 32'h0);
      model_reset();
      s_rst = 1'b1;
      cycle();
      s_rst = 1'b0;
      idle_inputs();
      cycle();
      cycle();

      @(negedge MCLK);
      #3;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
